board_judge: RTL and testbench

BOARD_JUDGE -- requirements
Module: board_judge

---
 rtl/board_judge.sv | 140 ++++++++++++++
 tb/tb_board_judge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_judge.sv
// board_judge: drop-game referee; places a piece, then scans one line direction per cycle
// around it and reports win, tie or next turn.
module board_judge #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 move_valid,
  input  logic [2:0]           move_col,
  output logic                 move_ready,
  output logic                 move_ack,
  output logic                 move_reject,
  output logic [1:0]           game_status,
  output logic                 player_turn,
  output logic [ROWS*COLS-1:0] board_p1,
  output logic [ROWS*COLS-1:0] board_p2,
  output logic [5:0]           piece_count
);
  localparam int N = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam logic [1:0] IDLE = 2'd0, PLACE = 2'd1, CHECK = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d, dir_q, dir_d, status_q, status_d;
  logic [2:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d, low;
  logic [N-1:0] p1_q, p1_d, p2_q, p2_d, occ, mine;
  logic [5:0] cnt_q, cnt_d;
  logic [IW-1:0] pidx, tidx;
  logic turn_q, turn_d, win_q, win_d, ack_q, ack_d, rej_q, rej_d, hit;
  int len;
  assign occ = p1_q | p2_q;
  assign mine = turn_q ? p2_q : p1_q;
  assign tidx = IW'((ROWS - 1) * COLS + int'(move_col));
  assign pidx = IW'(int'(low) * COLS + int'(col_q));
  assign hit = len >= WIN_LEN;
  // the last empty cell seen scanning downward is the landing row
  always_comb begin
    low = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!occ[IW'(r * COLS + int'(col_q))]) low = RW'(r);
  end
  // dir 0: horizontal, 1: vertical, 2: up-right, 3: down-right
  always_comb begin
    int dr, dc, r, c;
    logic run;
    dr = (dir_q == 2'd0) ? 0 : (dir_q == 2'd3) ? -1 : 1;
    dc = (dir_q == 2'd1) ? 0 : 1;
    len = 1;
    r = 0;
    c = 0;
    run = 1'b0;
    for (int s = 0; s < 2; s++) begin
      run = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r = int'(row_q) + ((s == 0) ? k : -k) * dr;
        c = int'(col_q) + ((s == 0) ? k : -k) * dc;
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) run = 1'b0;
        else if (!mine[IW'(r * COLS + c)]) run = 1'b0;
        if (run) len = len + 1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    col_d = col_q;
    row_d = row_q;
    p1_d = p1_q;
    p2_d = p2_q;
    cnt_d = cnt_q;
    turn_d = turn_q;
    status_d = status_q;
    win_d = win_q;
    ack_d = 1'b0;
    rej_d = 1'b0;
    if (state_q == IDLE && move_valid) begin
      rej_d = int'(move_col) >= COLS || occ[tidx];
      state_d = rej_d ? IDLE : PLACE;
      col_d = move_col;
    end
    if (state_q == PLACE) begin
      if (turn_q) p2_d[pidx] = 1'b1;
      else p1_d[pidx] = 1'b1;
      row_d = low;
      cnt_d = cnt_q + 6'd1;
      win_d = 1'b0;
      dir_d = 2'd0;
      state_d = CHECK;
    end
    if (state_q == CHECK) begin
      win_d = win_q | hit;
      dir_d = dir_q + 2'd1;
      if (dir_q == 2'd3) begin
        ack_d = 1'b1;
        status_d = win_d ? {turn_q, !turn_q} : (cnt_q == 6'(N)) ? 2'b11 : 2'b00;
        turn_d = (status_d == 2'b00) ? !turn_q : turn_q;
        state_d = (status_d == 2'b00) ? IDLE : DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q <= '0;
      col_q <= '0;
      row_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      cnt_q <= '0;
      turn_q <= 1'b0;
      status_q <= 2'b00;
      win_q <= 1'b0;
      ack_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      col_q <= col_d;
      row_q <= row_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      cnt_q <= cnt_d;
      turn_q <= turn_d;
      status_q <= status_d;
      win_q <= win_d;
      ack_q <= ack_d;
      rej_q <= rej_d;
    end
  end
  assign move_ready = state_q == IDLE;
  assign move_ack = ack_q;
  assign move_reject = rej_q;
  assign game_status = status_q;
  assign player_turn = turn_q;
  assign board_p1 = p1_q;
  assign board_p2 = p2_q;
  assign piece_count = cnt_q;
endmodule

// File: tb/tb_board_judge.sv
// tb_board_judge: directed and randomized play of board_judge checked every cycle against
// a grid-level game model that scans whole lines for wins.
module tb_board_judge;
  localparam int ROWS = 6, COLS = 7, WIN_LEN = 4, N = ROWS * COLS;
  logic clk = 1'b0, reset = 1'b0, move_valid = 1'b0;
  logic [2:0] move_col = '0;
  logic move_ready, move_ack, move_reject, player_turn;
  logic [1:0] game_status;
  logic [N-1:0] board_p1, board_p2;
  logic [5:0] piece_count;
  int n_chk = 0, n_pass = 0;
  int grid [ROWS][COLS];
  int ph, pc, mturn, mstat, mcnt;
  bit mdone, chk_en = 1'b0;
  logic exp_ready, exp_ack, exp_rej;
  int mv [$];

  board_judge #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .move_ack(move_ack), .move_reject(move_reject),
    .game_status(game_status), .player_turn(player_turn),
    .board_p1(board_p1), .board_p2(board_p2), .piece_count(piece_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] mboard(int p);
    logic [63:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (grid[r][c] == p) b[r * COLS + c] = 1'b1;
    return b;
  endfunction

  // any run of WIN_LEN cells of player p anywhere on the grid
  function automatic bit wins(int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok;
          ok = 1'b1;
          for (int k = 0; k < WIN_LEN; k++) begin
            int rr, cc;
            rr = r + k * dr[d];
            cc = c + k * dc[d];
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (grid[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 0;
    ph = 0; pc = 0; mturn = 0; mstat = 0; mcnt = 0; mdone = 1'b0;
    exp_ack = 1'b0; exp_rej = 1'b0; exp_ready = 1'b1;
  endtask

  // ph counts edges since the accepting edge; the verdict lands five edges later
  task automatic model_edge(input logic v, input logic [2:0] c);
    int h;
    if (reset) return;
    exp_ack = 1'b0;
    exp_rej = 1'b0;
    if (ph == 0) begin
      if (v && !mdone) begin
        if (int'(c) >= COLS || grid[ROWS-1][c] != 0) exp_rej = 1'b1;
        else begin ph = 1; pc = int'(c); end
      end
    end else if (ph == 1) begin
      h = 0;
      for (int r = 0; r < ROWS; r++) if (grid[r][pc] != 0) h++;
      grid[h][pc] = mturn + 1;
      mcnt++;
      ph = 2;
    end else if (ph < 5) ph++;
    else begin
      ph = 0;
      exp_ack = 1'b1;
      if (wins(mturn + 1)) begin mstat = (mturn == 1) ? 2 : 1; mdone = 1'b1; end
      else if (mcnt == N) begin mstat = 3; mdone = 1'b1; end
      else mturn = 1 - mturn;
    end
    exp_ready = (ph == 0) && !mdone;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ready", 64'(move_ready), 64'(exp_ready));
    chk("ack", 64'(move_ack), 64'(exp_ack));
    chk("reject", 64'(move_reject), 64'(exp_rej));
    chk("status", 64'(game_status), 64'(mstat));
    chk("turn", 64'(player_turn), 64'(mturn));
    chk("count", 64'(piece_count), 64'(mcnt));
    chk("board_p1", 64'(board_p1), mboard(1));
    chk("board_p2", 64'(board_p2), mboard(2));
  end

  task automatic step(input logic v, input logic [2:0] c);
    move_valid = v;
    move_col = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    reset = 1'b0;
  endtask

  task automatic play(input int c);
    int n;
    n = 0;
    while (!exp_ready && n < 20) begin step(1'b0, 3'd0); n++; end
    if (!exp_ready) begin
      n_chk++;
      $display("FAIL play_wait: got not ready after %0d cycles, expected ready", n);
    end
    step(1'b1, 3'(c));
    repeat (6) step(1'b0, 3'd0);
  endtask

  task automatic run_mv();
    foreach (mv[i]) play(mv[i]);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    mv.push_back(a); mv.push_back(b); mv.push_back(c); mv.push_back(d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400us, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, evts;
    #1;
    chk_en = 1'b1;
    do_reset();
    chk("reset_count", 64'(piece_count), 64'd0);
    // first drop, column 3
    step(1'b1, 3'd3);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (move_ack && lat == 0) lat = k;
      step(1'b0, 3'd0);
    end
    chk("ack_latency", 64'(lat), 64'd6);
    chk("first_p1", 64'(board_p1), 64'h8);
    chk("first_turn", 64'(player_turn), 64'd1);
    chk("first_status", 64'(game_status), 64'd0);
    chk("first_count", 64'(piece_count), 64'd1);
    // horizontal P1 win, then the board is frozen
    do_reset();
    mv = '{0, 6, 1, 6, 2, 6, 3};
    run_mv();
    chk("p1_win", 64'(game_status), 64'd1);
    evts = 0;
    repeat (8) begin step(1'b1, 3'd4); evts += int'(move_ack) + int'(move_reject); end
    step(1'b0, 3'd0);
    chk("done_silent", 64'(evts), 64'd0);
    // full column, out-of-range column
    do_reset();
    repeat (6) play(2);
    step(1'b1, 3'd2);
    chk("full_reject", 64'(move_reject), 64'd1);
    step(1'b0, 3'd0);
    chk("reject_pulse", 64'(move_reject), 64'd0);
    chk("full_turn", 64'(player_turn), 64'd0);
    chk("full_p1", 64'(board_p1), 64'h4001_0004);
    chk("full_p2", 64'(board_p2), 64'h20_0080_0200);
    step(1'b1, 3'd7);
    chk("col7_reject", 64'(move_reject), 64'd1);
    step(1'b0, 3'd0);
    // P1 on bits 4..7 must not wrap into a win
    do_reset();
    mv = '{4, 0, 5, 1, 6, 1, 0};
    run_mv();
    chk("nowrap_status", 64'(game_status), 64'd0);
    chk("nowrap_p1", 64'(board_p1), 64'hF0);
    chk("nowrap_p2", 64'(board_p2), 64'h103);
    // P2 down-right diagonal (3,0)..(0,3)
    do_reset();
    mv = '{0, 3, 1, 0, 1, 2, 0, 2, 5, 1, 5, 0};
    run_mv();
    chk("diag_p2", 64'(game_status), 64'd2);
    // full board with no line
    do_reset();
    mv = {};
    repeat (3) push4(0, 2, 2, 0);
    repeat (3) push4(1, 3, 3, 1);
    repeat (3) push4(4, 6, 6, 4);
    repeat (3) push4(5, 5, 5, 5);
    mv = mv[0:41];
    run_mv();
    chk("tie_status", 64'(game_status), 64'd3);
    chk("tie_count", 64'(piece_count), 64'd42);
    // 42nd piece completes top row c2..c5 for P2
    do_reset();
    mv = {};
    repeat (2) push4(0, 2, 2, 0);
    push4(0, 2, 0, 2);
    repeat (2) push4(1, 3, 3, 1);
    push4(1, 3, 1, 3);
    repeat (3) push4(4, 6, 6, 4);
    repeat (3) push4(5, 5, 5, 5);
    mv = mv[0:41];
    run_mv();
    chk("last_win", 64'(game_status), 64'd2);
    chk("last_count", 64'(piece_count), 64'd42);
    // reset while a move is being checked
    do_reset();
    play(3);
    play(4);
    step(1'b1, 3'd2);
    repeat (3) step(1'b0, 3'd0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_count", 64'(piece_count), 64'd0);
    chk("mid_p1", 64'(board_p1), 64'd0);
    chk("mid_ack", 64'(move_ack), 64'd0);
    repeat (2) step(1'b0, 3'd0);
    reset = 1'b0;
    evts = 0;
    repeat (8) begin step(1'b0, 3'd0); evts += int'(move_ack); end
    chk("mid_noack", 64'(evts), 64'd0);
    chk("mid_ready", 64'(move_ready), 64'd1);
    // random play with idle gaps, illegal columns and stray resets
    for (int g = 0; g < 12; g++) begin
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
        if ($urandom_range(0, 299) == 0) begin
          reset = 1'b1;
          model_reset();
          step(1'b0, 3'd0);
          reset = 1'b0;
        end
      end
    end
    step(1'b0, 3'd0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
